// File: rtl/coeff_bank_if.sv
// ---------------------------------------------------------------------------
// coeff_bank_if
//   Bundles the coefficient-load bus from the fetch stage, the frame-swap
//   request, the random read port and the status flags of coeff_bank.
//
//   master : fetch stage / datapath side (drives writes, swap request, reads)
//   slave  : coeff_bank side (returns read data and status)
//
//   wr_data, wr_addr, w_e : coefficient write, one per cycle while w_e is high
//   coeff_ready           : fetch stage done, rising edge is used
//   frame_start           : one-cycle swap request
//   rd_idx / rd_data      : read index and registered read data
//   active_valid          : active bank holds a complete set
//   shadow_full           : shadow bank complete, swap pending
//   swap_done, swap_miss  : one-cycle swap outcome pulses
//   load_err              : sticky load error
// ---------------------------------------------------------------------------
interface coeff_bank_if #(
    parameter int COEFF_ADDR_SIZE = 5,
    parameter int DATA_SIZE       = 32
);
    logic [DATA_SIZE-1:0]       wr_data;
    logic [COEFF_ADDR_SIZE-1:0] wr_addr;
    logic                       w_e;
    logic                       coeff_ready;
    logic                       frame_start;
    logic [COEFF_ADDR_SIZE-1:0] rd_idx;
    logic [DATA_SIZE-1:0]       rd_data;
    logic                       active_valid;
    logic                       shadow_full;
    logic                       swap_done;
    logic                       swap_miss;
    logic                       load_err;

    modport master (
        output wr_data, wr_addr, w_e, coeff_ready, frame_start, rd_idx,
        input  rd_data, active_valid, shadow_full, swap_done, swap_miss, load_err
    );

    modport slave (
        input  wr_data, wr_addr, w_e, coeff_ready, frame_start, rd_idx,
        output rd_data, active_valid, shadow_full, swap_done, swap_miss, load_err
    );
endinterface

// File: rtl/coeff_bank.sv
// ---------------------------------------------------------------------------
// coeff_bank
//   Double-buffered coefficient store. The fetch stage fills the shadow bank
//   one coefficient per cycle; once coeff_ready rises with every index
//   written, the shadow bank is marked full and becomes active at the next
//   frame_start. Reads always come from the active bank with one cycle of
//   latency, so a coefficient set never changes in the middle of a frame.
//
//   clk  : system clock, rising edge
//   RST  : asynchronous active-high reset
//   bus  : coeff_bank_if.slave (write bus, swap request, read port, status)
// ---------------------------------------------------------------------------
module coeff_bank #(
    parameter int COEFF_ADDR_SIZE = 5,
    parameter int COEFF_NB        = 26,
    parameter int DATA_SIZE       = 32
) (
    input  logic          clk,
    input  logic          RST,
    coeff_bank_if.slave   bus
);
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        LOADING = 2'd1,
        FULL    = 2'd2
    } shadow_state_t;

    localparam logic [COEFF_ADDR_SIZE:0] NB = (COEFF_ADDR_SIZE + 1)'(COEFF_NB);

    // NOTE: coefficient storage has no reset; its contents are only
    // meaningful once a complete set has been loaded and swapped in.
    logic [DATA_SIZE-1:0] bank_mem [2][COEFF_NB];

    shadow_state_t        state;
    logic                 ptr;           // index of the active bank
    logic [COEFF_NB-1:0]  mask;          // shadow indices written so far
    logic                 coeff_ready_q; // for rising-edge detection

    logic addr_ok;
    logic rd_ok;
    logic wr_accept;
    logic ready_rise;
    logic swap;

    assign addr_ok    = {1'b0, bus.wr_addr} < NB;
    assign rd_ok      = {1'b0, bus.rd_idx} < NB;
    assign wr_accept  = bus.w_e && (state != FULL) && addr_ok;
    assign ready_rise = bus.coeff_ready && !coeff_ready_q;
    assign swap       = bus.frame_start && (state == FULL);

    // Shadow writes land in the bank the pointer is not selecting.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            bank_mem[~ptr][bus.wr_addr] <= bus.wr_data;
        end
    end

    // Read uses the pointer value before any swap at this edge, so a read
    // issued in the swap cycle still returns the outgoing set.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            bus.rd_data <= '0;
        end else begin
            bus.rd_data <= rd_ok ? bank_mem[ptr][bus.rd_idx] : '0;
        end
    end

    // Shadow FSM, bank pointer and status flags.
    // NOTE: all sequential state uses non-blocking assignments so every
    // decision below sees the values from before this edge.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state            <= EMPTY;
            ptr              <= 1'b0;
            mask             <= '0;
            coeff_ready_q    <= 1'b0;
            bus.active_valid <= 1'b0;
            bus.shadow_full  <= 1'b0;
            bus.swap_done    <= 1'b0;
            bus.swap_miss    <= 1'b0;
            bus.load_err     <= 1'b0;
        end else begin
            coeff_ready_q <= bus.coeff_ready;
            bus.swap_done <= 1'b0;
            bus.swap_miss <= 1'b0;

            // Dropped writes: index out of range, or shadow already full.
            if (bus.w_e && !wr_accept) begin
                bus.load_err <= 1'b1;
            end

            if (swap) begin
                ptr              <= ~ptr;
                bus.active_valid <= 1'b1;
                bus.swap_done    <= 1'b1;
                bus.shadow_full  <= 1'b0;
                mask             <= '0;
                state            <= EMPTY;
            end else begin
                if (bus.frame_start) begin
                    bus.swap_miss <= 1'b1;
                end

                if (wr_accept) begin
                    mask[bus.wr_addr] <= 1'b1;
                    if (state == EMPTY) begin
                        state <= LOADING;
                    end
                end

                // Completeness is judged on writes from earlier cycles only.
                if (ready_rise && state == LOADING) begin
                    if (&mask) begin
                        state           <= FULL;
                        bus.shadow_full <= 1'b1;
                    end else begin
                        bus.load_err <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_coeff_bank.sv
// ---------------------------------------------------------------------------
// tb_coeff_bank
//   Directed bench for coeff_bank. A set-level model (two coefficient sets,
//   which one is live, which shadow indices are loaded) predicts every output
//   each cycle; directed sequences add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_coeff_bank;
    localparam int AW = 5;
    localparam int NB = 26;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_tb = 1'b0;
    bit   cmp_en = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    coeff_bank_if #(.COEFF_ADDR_SIZE(AW), .DATA_SIZE(DW)) bus ();

    coeff_bank #(.COEFF_ADDR_SIZE(AW), .COEFF_NB(NB), .DATA_SIZE(DW)) dut (
        .clk (clk),
        .RST (rst_tb),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Set-level model
    // ------------------------------------------------------------------
    int unsigned set_val   [2][NB];
    bit          set_known [2][NB];
    int          live;            // which of the two sets is being served
    bit          loaded    [NB];  // shadow indices loaded since last swap
    bit          any_loaded;
    bit          ready_set;       // shadow set declared complete
    bit          prev_ready;

    logic [31:0] e_rd;
    bit          e_rd_known;
    bit          e_av, e_sf, e_sd, e_sm, e_le;

    always @(posedge clk or posedge rst_tb) begin : model
        bit rise;
        bit complete;
        bit was_ready;
        int a;
        int r;
        if (rst_tb) begin
            live       = 0;
            loaded     = '{default: 1'b0};
            any_loaded = 1'b0;
            ready_set  = 1'b0;
            prev_ready = 1'b0;
            e_rd       = '0;
            e_rd_known = 1'b1;
            e_av = 1'b0; e_sf = 1'b0; e_sd = 1'b0; e_sm = 1'b0; e_le = 1'b0;
        end else begin
            a         = int'(bus.wr_addr);
            r         = int'(bus.rd_idx);
            rise      = bus.coeff_ready && !prev_ready;
            prev_ready = bus.coeff_ready;
            was_ready = ready_set;
            complete  = 1'b1;
            for (int i = 0; i < NB; i++) if (!loaded[i]) complete = 1'b0;

            if (r >= NB) begin
                e_rd = '0;
                e_rd_known = 1'b1;
            end else begin
                e_rd = set_val[live][r];
                e_rd_known = set_known[live][r];
            end

            e_sd = 1'b0;
            e_sm = 1'b0;
            if (bus.w_e && (was_ready || a >= NB)) e_le = 1'b1;

            if (bus.frame_start && was_ready) begin
                live       = 1 - live;
                e_av       = 1'b1;
                e_sd       = 1'b1;
                e_sf       = 1'b0;
                ready_set  = 1'b0;
                any_loaded = 1'b0;
                loaded     = '{default: 1'b0};
            end else begin
                if (bus.frame_start) e_sm = 1'b1;
                if (rise && any_loaded) begin
                    if (complete) begin
                        ready_set = 1'b1;
                        e_sf = 1'b1;
                    end else begin
                        e_le = 1'b1;
                    end
                end
                if (bus.w_e && !was_ready && a < NB) begin
                    set_val[1 - live][a]   = bus.wr_data;
                    set_known[1 - live][a] = 1'b1;
                    loaded[a]  = 1'b1;
                    any_loaded = 1'b1;
                end
            end
        end
    end

    // One compare process, every cycle, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            if (e_rd_known) check("model rd_data", bus.rd_data, e_rd);
            check("model active_valid", 32'(bus.active_valid), 32'(e_av));
            check("model shadow_full",  32'(bus.shadow_full),  32'(e_sf));
            check("model swap_done",    32'(bus.swap_done),    32'(e_sd));
            check("model swap_miss",    32'(bus.swap_miss),    32'(e_sm));
            check("model load_err",     32'(bus.load_err),     32'(e_le));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_tb = 1'b1;
        tick();
        tick();
        rst_tb = 1'b0;
    endtask

    task automatic load_range(input int base, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            bus.wr_addr = AW'(i);
            bus.wr_data = DW'(base + i);
            bus.w_e     = 1'b1;
            tick();
        end
        bus.w_e = 1'b0;
    endtask

    task automatic ready_pulse();
        bus.coeff_ready = 1'b1;
        tick();
        bus.coeff_ready = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " rd_data"},      bus.rd_data,             32'h0);
        check({tag, " active_valid"}, 32'(bus.active_valid),   32'h0);
        check({tag, " shadow_full"},  32'(bus.shadow_full),    32'h0);
        check({tag, " swap_done"},    32'(bus.swap_done),      32'h0);
        check({tag, " swap_miss"},    32'(bus.swap_miss),      32'h0);
        check({tag, " load_err"},     32'(bus.load_err),       32'h0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bus.wr_data     = '0;
        bus.wr_addr     = '0;
        bus.w_e         = 1'b0;
        bus.coeff_ready = 1'b0;
        bus.frame_start = 1'b0;
        bus.rd_idx      = '0;

        #1;
        rst_tb = 1'b1;
        cmp_en = 1'b1;
        tick();
        check_all_zero("reset");
        tick();
        rst_tb = 1'b0;

        // Full load then swap.
        load_range(32'h1000, 0, NB - 1);
        check("t1 shadow_full before ready", 32'(bus.shadow_full), 32'h0);
        bus.coeff_ready = 1'b1;
        tick();
        check("t1 shadow_full", 32'(bus.shadow_full), 32'h1);
        bus.coeff_ready = 1'b0;
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        check("t1 swap_done",    32'(bus.swap_done),    32'h1);
        check("t1 active_valid", 32'(bus.active_valid), 32'h1);
        check("t1 shadow_full cleared", 32'(bus.shadow_full), 32'h0);
        bus.rd_idx = AW'(7);
        tick();
        check("t1 swap_done pulse", 32'(bus.swap_done), 32'h0);
        check("t1 rd idx7", bus.rd_data, 32'h1007);

        // Incomplete load.
        do_reset();
        load_range(32'h2000, 0, NB - 2);
        ready_pulse();
        check("t2 load_err",    32'(bus.load_err),    32'h1);
        check("t2 shadow_full", 32'(bus.shadow_full), 32'h0);
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        check("t2 swap_miss",    32'(bus.swap_miss),    32'h1);
        check("t2 active_valid", 32'(bus.active_valid), 32'h0);
        tick();
        check("t2 swap_miss pulse", 32'(bus.swap_miss), 32'h0);

        // Out-of-range write and write while full.
        do_reset();
        bus.wr_addr = AW'(26);
        bus.wr_data = 32'h0BAD;
        bus.w_e     = 1'b1;
        tick();
        bus.w_e = 1'b0;
        check("t3 load_err range", 32'(bus.load_err), 32'h1);
        load_range(32'h3000, 0, NB - 1);
        ready_pulse();
        check("t3 shadow_full", 32'(bus.shadow_full), 32'h1);
        bus.wr_addr = AW'(3);
        bus.wr_data = 32'hDEAD;
        bus.w_e     = 1'b1;
        tick();
        bus.w_e = 1'b0;
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        check("t3 swap_done", 32'(bus.swap_done), 32'h1);
        bus.rd_idx = AW'(3);
        tick();
        check("t3 rd idx3", bus.rd_data, 32'h3003);
        bus.rd_idx = AW'(26);
        tick();
        check("t3 rd idx26", bus.rd_data, 32'h0);
        bus.rd_idx = AW'(31);
        tick();
        check("t3 rd idx31", bus.rd_data, 32'h0);

        // Double buffering, with a write colliding with the swap.
        do_reset();
        load_range(32'hA000, 0, NB - 1);
        ready_pulse();
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        bus.rd_idx = AW'(5);
        tick();
        check("t4 rd A5", bus.rd_data, 32'hA005);
        for (int i = 0; i < NB; i++) begin
            bus.wr_addr = AW'(i);
            bus.wr_data = DW'(32'hB000 + i);
            bus.w_e     = 1'b1;
            tick();
            check("t4 rd A5 during load", bus.rd_data, 32'hA005);
        end
        bus.w_e = 1'b0;
        ready_pulse();
        check("t4 shadow_full", 32'(bus.shadow_full), 32'h1);
        check("t4 load_err clean", 32'(bus.load_err), 32'h0);
        bus.frame_start = 1'b1;
        bus.w_e         = 1'b1;
        bus.wr_addr     = AW'(5);
        bus.wr_data     = 32'h5555;
        tick();
        bus.frame_start = 1'b0;
        bus.w_e         = 1'b0;
        check("t4 rd in swap cycle", bus.rd_data, 32'hA005);
        check("t4 swap_done", 32'(bus.swap_done), 32'h1);
        check("t4 load_err collide", 32'(bus.load_err), 32'h1);
        tick();
        check("t4 rd B5", bus.rd_data, 32'hB005);

        // Same-cycle coeff_ready edge and frame_start.
        load_range(32'hC000, 0, NB - 1);
        bus.coeff_ready = 1'b1;
        bus.frame_start = 1'b1;
        tick();
        bus.coeff_ready = 1'b0;
        bus.frame_start = 1'b0;
        check("t5 swap_miss",   32'(bus.swap_miss),   32'h1);
        check("t5 shadow_full", 32'(bus.shadow_full), 32'h1);
        check("t5 no swap_done", 32'(bus.swap_done),  32'h0);
        tick();
        check("t5 rd still B5", bus.rd_data, 32'hB005);
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        check("t5 swap_done", 32'(bus.swap_done), 32'h1);
        tick();
        check("t5 rd C5", bus.rd_data, 32'hC005);

        // Async reset in the middle of a load.
        bus.rd_idx = AW'(2);
        load_range(32'hE000, 0, 10);
        check("t6 rd C2", bus.rd_data, 32'hC002);
        #3;
        rst_tb = 1'b1;
        #1;
        check_all_zero("t6 async");
        tick();
        rst_tb = 1'b0;
        load_range(32'hF000, 0, NB - 1);
        ready_pulse();
        check("t6 shadow_full", 32'(bus.shadow_full), 32'h1);
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        check("t6 swap_done", 32'(bus.swap_done), 32'h1);
        bus.rd_idx = AW'(25);
        tick();
        check("t6 rd idx25", bus.rd_data, 32'hF019);
        tick();

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
